// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, immediate sign extension,
// and a destination scoreboard that stalls incoming RAW/WAW hazards.
module decode_stage #(
  parameter int REG_ADDR_W  = 6,
  parameter int OP_W        = 4,
  parameter int IMM_IN_W    = 9,
  parameter int IMM_OUT_W   = 16,
  parameter bit ZERO_REG_EN = 1'b1,
  localparam int INST_W     = 1 + 3*REG_ADDR_W + OP_W + IMM_IN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_muxsel,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [OP_W-1:0]       out_aluop,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [IMM_OUT_W-1:0]  out_imm,
  output logic                  out_regwrite,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  pending_any
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int RT_LSB   = IMM_IN_W;
  localparam int OP_LSB   = RT_LSB + REG_ADDR_W;
  localparam int RS_LSB   = OP_LSB + OP_W;
  localparam int RD_LSB   = RS_LSB + REG_ADDR_W;

  logic                  d_muxsel;
  logic [REG_ADDR_W-1:0] d_rd, d_rs, d_rt;
  logic [OP_W-1:0]       d_aluop;
  logic [IMM_IN_W-1:0]   d_imm_raw;
  logic [IMM_OUT_W-1:0]  d_imm;
  logic                  d_regwrite;

  assign d_muxsel   = in_inst[INST_W-1];
  assign d_rd       = in_inst[RD_LSB +: REG_ADDR_W];
  assign d_rs       = in_inst[RS_LSB +: REG_ADDR_W];
  assign d_aluop    = in_inst[OP_LSB +: OP_W];
  assign d_rt       = in_inst[RT_LSB +: REG_ADDR_W];
  assign d_imm_raw  = in_inst[IMM_IN_W-1:0];
  assign d_imm      = IMM_OUT_W'($signed(d_imm_raw));
  assign d_regwrite = (d_aluop != '0);

  logic [NUM_REGS-1:0] pending, pending_eff, pending_nxt, wb_mask, set_mask;
  logic                issue, accept, hazard, busy_vld;

  // A register is busy if it is pending (after same-cycle writeback bypass)
  // or is the destination of the decoded-but-not-yet-issued instruction.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [NUM_REGS-1:0]   pend,
                                     input logic                  bvld,
                                     input logic [REG_ADDR_W-1:0] brd);
    if (ZERO_REG_EN && (r == '0)) return 1'b0;
    return pend[r] | (bvld & (brd == r));
  endfunction

  assign wb_mask     = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
  assign pending_eff = pending & ~wb_mask;
  assign busy_vld    = out_valid & out_regwrite;

  assign hazard = reg_match(d_rs, pending_eff, busy_vld, out_rd)
                | (!d_muxsel  & reg_match(d_rt, pending_eff, busy_vld, out_rd))
                | (d_regwrite & reg_match(d_rd, pending_eff, busy_vld, out_rd));

  assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;
  // A flushed instruction must never reach the scoreboard.
  assign issue    = out_valid & out_ready & !flush;

  assign set_mask = (issue && out_regwrite && !(ZERO_REG_EN && (out_rd == '0)))
                    ? (NUM_REGS'(1) << out_rd) : '0;
  assign pending_nxt = (pending & ~wb_mask) | set_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      pending_any <= 1'b0;
    end else begin
      pending     <= pending_nxt;
      pending_any <= |pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_muxsel   <= 1'b0;
      out_rd       <= '0;
      out_rs       <= '0;
      out_aluop    <= '0;
      out_rt       <= '0;
      out_imm      <= '0;
      out_regwrite <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_muxsel   <= d_muxsel;
      out_rd       <= d_rd;
      out_rs       <= d_rs;
      out_aluop    <= d_aluop;
      out_rt       <= d_rt;
      out_imm      <= d_imm;
      out_regwrite <= d_regwrite;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, directed hazard,
// backpressure and flush/reset sequences, then random traffic against a model.
module tb_decode_stage;

  typedef struct packed {
    logic       mux;
    logic [5:0] rd;
    logic [5:0] rs;
    logic [3:0] op;
    logic [5:0] rt;
    logic [15:0] imm;
    logic       rw;
  } fields_t;

  typedef struct {
    logic [31:0] inst;
    fields_t     exp;
    logic        pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_muxsel;
  logic [5:0]  out_rd, out_rs, out_rt;
  logic [3:0]  out_aluop;
  logic [15:0] out_imm;
  logic        out_regwrite;
  logic        wb_valid = 1'b0;
  logic [5:0]  wb_rd = '0;
  logic        pending_any;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_muxsel(out_muxsel), .out_rd(out_rd), .out_rs(out_rs), .out_aluop(out_aluop),
    .out_rt(out_rt), .out_imm(out_imm), .out_regwrite(out_regwrite),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  fields_t act_f;
  assign act_f = {out_muxsel, out_rd, out_rs, out_aluop, out_rt, out_imm, out_regwrite};

  int checks = 0;
  int failures = 0;

  // reference model state
  logic        m_valid;
  fields_t     m_out;
  logic [63:0] m_pend;
  logic        last_rdy;
  logic [15:0] issued[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic fields_t mkf(logic mux, logic [5:0] rd, logic [5:0] rs, logic [3:0] op,
                                  logic [5:0] rt, logic [15:0] imm, logic rw);
    return {mux, rd, rs, op, rt, imm, rw};
  endfunction

  function automatic fields_t decode_ref(logic [31:0] w);
    fields_t f;
    int unsigned imm9;
    f.mux = w[31];
    f.rd  = 6'((w >> 25) & 32'h3F);
    f.rs  = 6'((w >> 19) & 32'h3F);
    f.op  = 4'((w >> 15) & 32'hF);
    f.rt  = 6'((w >> 9) & 32'h3F);
    imm9  = w & 32'h1FF;
    f.imm = (imm9 >= 256) ? 16'(imm9 + 32'hFE00) : 16'(imm9);
    f.rw  = (f.op != 0);
    return f;
  endfunction

  function automatic logic m_match(logic [5:0] r, logic wbv, logic [5:0] wbrd);
    if (r == 0) return 1'b0;
    return (m_pend[r] && !(wbv && wbrd == r)) || (m_valid && m_out.rw && m_out.rd == r);
  endfunction

  task automatic model_clear();
    m_valid = 1'b0;
    m_out   = '0;
    m_pend  = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_fields", 64'(act_f), 64'(m_out));
    chk("pending_any", 64'(pending_any), 64'(|m_pend));
  endtask

  // Asynchronous reset asserted at the current time, released on the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_fields", 64'(act_f), 64'(0));
    chk("rst_pend", 64'(pending_any), 64'(0));
    model_clear();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic iv, input logic [31:0] inst, input logic ordy,
                      input logic fl, input logic wbv, input logic [5:0] wbrd,
                      output logic acc);
    fields_t f;
    logic hz, er, iss;
    @(negedge clk);
    in_valid = iv; in_inst = inst; out_ready = ordy; flush = fl; wb_valid = wbv; wb_rd = wbrd;
    #1;
    f  = decode_ref(inst);
    hz = m_match(f.rs, wbv, wbrd) | (!f.mux && m_match(f.rt, wbv, wbrd))
       | (f.rw && m_match(f.rd, wbv, wbrd));
    er = (!m_valid || ordy) && !hz && !fl;
    last_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(er));
    if (out_valid && ordy && !fl) issued.push_back(out_imm);
    acc = iv && er;
    iss = m_valid && ordy && !fl;
    @(posedge clk);
    if (wbv) m_pend[wbrd] = 1'b0;
    if (iss && m_out.rw && m_out.rd != 0) m_pend[m_out.rd] = 1'b1;
    if (fl) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_out = f; end
    else if (ordy) m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  vec_t        vecs[5];
  logic [31:0] bw[8];
  logic        acc;
  int          idx;
  int          guard;

  initial begin
    vecs[0] = '{32'h8A1901F0, mkf(1, 5, 3, 2, 0, 16'hFFF0, 1), 1'b1};
    vecs[1] = '{32'h0E0804FF, mkf(0, 7, 1, 0, 2, 16'h00FF, 0), 1'b0};
    vecs[2] = '{32'h01FFFF00, mkf(0, 0, 63, 15, 63, 16'hFF00, 1), 1'b0};
    vecs[3] = '{32'hFE008000, mkf(1, 63, 0, 1, 0, 16'h0000, 1), 1'b1};
    vecs[4] = '{32'hFFFFFFFF, mkf(1, 63, 63, 15, 63, 16'hFFFF, 1), 1'b1};
    for (int i = 0; i < 8; i++) bw[i] = 32'h80000000 | ((i + 1) << 19) | (i + 1);

    model_clear();
    #2;
    do_reset();

    // decode table: each word accepted into an empty stage, then issued
    for (int i = 0; i < 5; i++) begin
      do_reset();
      step(1, vecs[i].inst, 1, 0, 0, 0, acc);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
      chk($sformatf("tbl%0d_fields", i), 64'(act_f), 64'(vecs[i].exp));
      step(0, 0, 1, 0, 0, 0, acc);
      chk($sformatf("tbl%0d_pend", i), 64'(pending_any), 64'(vecs[i].pend));
    end

    // RAW hazard on r5, released by a same-cycle writeback
    do_reset();
    step(1, 32'h8A1901F0, 1, 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h82280000, 1, 0, 0, 0, acc);
      chk($sformatf("hz_stall%0d", k), 64'(last_rdy), 64'(0));
    end
    step(1, 32'h82280000, 1, 0, 1, 6'd5, acc);
    chk("hz_release_rdy", 64'(last_rdy), 64'(1));
    chk("hz_release_valid", 64'(out_valid), 64'(1));
    chk("hz_release_rs", 64'(out_rs), 64'(5));
    chk("hz_release_pend", 64'(pending_any), 64'(0));

    // back-to-back: rt=7 against r7 in the output register
    do_reset();
    step(1, 32'h8E008000, 1, 0, 0, 0, acc);
    step(1, 32'h04000E00, 1, 0, 0, 0, acc);
    chk("b2b_rt_stall", 64'(last_rdy), 64'(0));
    do_reset();
    step(1, 32'h8E008000, 1, 0, 0, 0, acc);
    step(1, 32'h84000E00, 1, 0, 0, 0, acc);
    chk("b2b_imm_nostall", 64'(last_rdy), 64'(1));

    // backpressure for 4 cycles, then 8 words must issue in order exactly once
    do_reset();
    issued.delete();
    step(1, bw[0], 0, 0, 0, 0, acc);
    for (int k = 0; k < 4; k++) begin
      step(1, bw[1], 0, 0, 0, 0, acc);
      chk($sformatf("bp_rdy%0d", k), 64'(last_rdy), 64'(0));
      chk($sformatf("bp_hold%0d", k), 64'({out_valid, out_imm}), 64'({1'b1, 16'd1}));
    end
    idx = 1;
    guard = 0;
    while (idx < 8 && guard < 40) begin
      step(1, bw[idx], 1, 0, 0, 0, acc);
      if (acc) idx++;
      guard++;
    end
    chk("bp_all_accepted", 64'(idx), 64'(8));
    step(0, 0, 1, 0, 0, 0, acc);
    step(0, 0, 1, 0, 0, 0, acc);
    chk("bp_issue_count", 64'(issued.size()), 64'(8));
    for (int i = 0; i < 8 && i < issued.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(issued[i]), 64'(i + 1));

    // flush with backpressure, then reset in the middle of a stall
    do_reset();
    step(1, 32'h8A1901F0, 1, 0, 0, 0, acc);
    step(1, bw[0], 1, 0, 0, 0, acc);
    step(0, 0, 0, 1, 0, 0, acc);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_pend", 64'(pending_any), 64'(1));
    step(1, bw[1], 0, 0, 0, 0, acc);
    step(1, 32'h82280000, 0, 0, 0, 0, acc);
    chk("stall_before_rst", 64'({out_valid, last_rdy}), 64'({1'b1, 1'b0}));
    do_reset();

    // random traffic on a small register set to provoke hazards
    for (int n = 0; n < 800; n++) begin
      logic [31:0] w;
      w = ({31'd0, 1'($urandom % 2)} << 31) | (($urandom % 8) << 25) | (($urandom % 8) << 19)
        | (($urandom % 4) << 15) | (($urandom % 8) << 9) | ($urandom % 512);
      step(1'($urandom % 2), w, ($urandom % 4) != 0, ($urandom % 20) == 0,
           ($urandom % 3) == 0, 6'($urandom % 8), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode stage with a valid/ready handshake on both sides.
- Splits each instruction word into its fields and sign-extends the immediate.
- Tracks destinations of issued, not-yet-written-back instructions in a scoreboard, and stalls any incoming instruction that has a RAW or WAW hazard against them.
- Sits between instruction fetch and the register-file/ALU stage; the writeback stage clears the scoreboard.

Parameters:
- REG_ADDR_W, 6, register address width; the scoreboard covers NUM_REGS = 2**REG_ADDR_W registers.
- OP_W, 4, ALU opcode width.
- IMM_IN_W, 9, immediate field width in the instruction.
- IMM_OUT_W, 16, sign-extended immediate width. Must be >= IMM_IN_W.
- INST_W, 1+3*REG_ADDR_W+OP_W+IMM_IN_W (32 at defaults), instruction width. Derived, not overridable.
- ZERO_REG_EN, 1, when 1, register 0 is never marked pending and never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  INST_W  instruction word.
- flush  in  1  synchronous flush of the output register.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  downstream accepts.
- out_muxsel  out  1  operand select: 1 = immediate, 0 = rt.
- out_rd  out  REG_ADDR_W  destination register.
- out_rs  out  REG_ADDR_W  source register 1.
- out_aluop  out  OP_W  ALU opcode.
- out_rt  out  REG_ADDR_W  source register 2.
- out_imm  out  IMM_OUT_W  sign-extended immediate.
- out_regwrite  out  1  instruction writes rd.
- wb_valid  in  1  writeback completes this cycle.
- wb_rd  in  REG_ADDR_W  register written back.
- pending_any  out  1  OR of all scoreboard bits.

Behaviour:
- Field layout, MSB to LSB: muxsel | rd | rs | aluop | rt | imm. At defaults: muxsel[31], rd[30:25], rs[24:19], aluop[18:15], rt[14:9], imm[8:0].
- Immediate: imm replicated-sign-extended from bit IMM_IN_W-1 to IMM_OUT_W.
- regwrite = (aluop != 0).
- Reset (rst_n low, asynchronous): out_valid=0, every out_* field =0, scoreboard all 0, pending_any=0. Reset mid-stall or mid-transfer discards everything.
- One output register, latency 1: accepted on edge N, visible from N+1.
- Accept = in_valid & in_ready.
- in_ready = (!out_valid | out_ready) & !hazard & !flush. in_ready is combinational and may depend on in_valid/in_inst. in_valid must not depend on in_ready.
- Output holds stable while out_valid & !out_ready. Full throughput (one per cycle) when no hazard.
- Issue = out_valid & out_ready. On issue, if out_regwrite, set pending[out_rd].
- wb_valid clears pending[wb_rd] on the same edge.
- Same edge, same register, both set and clear: the set wins.
- Effective pending, used for the hazard check: pending & ~(wb_valid ? onehot(wb_rd) : 0). Writeback is therefore bypassed into the hazard check in the same cycle.
- Source/dest match: a register r matches if pending_eff[r], or if (out_valid & out_regwrite & out_rd==r), i.e. the not-yet-issued instruction in the output register.
- With ZERO_REG_EN=1, r==0 never matches and is never set.
- hazard = match(rs) | (!muxsel & match(rt)) | (regwrite & match(rd)), evaluated on in_inst.
- flush: out_valid cleared next edge. A flushed instruction never issues and never sets pending. Scoreboard is untouched, since in-flight writes remain. Flush overrides accept.
- pending_any is registered from the scoreboard.

Test Plan:
- Reset then in_inst=0x8A1901F0, in_valid=1, out_ready=1 -> next cycle: out_valid=1, muxsel=1, rd=5, rs=3, aluop=2, rt=0, imm=0xFFF0, regwrite=1. After issue, pending[5]=1 and pending_any=1.
- Data hazard: with r5 pending, present rs=5 -> in_ready=0 held for 3 cycles. Pulse wb_valid with wb_rd=5 -> in_ready=1 in the same cycle, and the instruction is accepted on that edge.
- Back-to-back hazard: write r7, then immediately present rt=7 with muxsel=0 -> stalled via the output-register match. The same word with muxsel=1 is accepted without stall.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> all outputs stable and in_ready=0. Release -> one issue per cycle, no loss or duplication over 8 words.
- aluop=0 -> regwrite=0 and no pending bit set. rd=0 with regwrite=1 -> pending stays 0 (ZERO_REG_EN=1).
- flush while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, pending unchanged. Assert rst_n low mid-stall -> all outputs and scoreboard 0 immediately.
